// File: rtl/axis_spi_reg_bridge.sv
`timescale 1ns/1ps
// Register-access bridge in front of the SPI master. Each command becomes
// one byte frame {rw, addr} + DATA_BYTES payload on the tx stream, and the
// echoed rx bytes are gathered into a single response.
//
//   state | meaning
//   IDLE  | ready for a command
//   XFER  | frame in flight, tx and rx running concurrently
//   RESP  | response presented, waiting for rsp_ready_i
module axis_spi_reg_bridge #(
   parameter int         ADDR_WIDTH = 7,
   parameter int         DATA_BYTES = 2,
   parameter int         SLAVE_NUM  = 2,
   parameter logic [7:0] DUMMY_BYTE = 8'h00,
   parameter int         TIMEOUT    = 4096
) (
   input  logic                         clk_i,
   input  logic                         arstn_i,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic                         cmd_rw_i,
   input  logic [ADDR_WIDTH-1:0]        cmd_addr_i,
   input  logic [8*DATA_BYTES-1:0]      cmd_wdata_i,
   input  logic [$clog2(SLAVE_NUM)-1:0] cmd_slave_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [8*DATA_BYTES-1:0]      rsp_rdata_o,
   output logic                         rsp_err_o,
   output logic [$clog2(SLAVE_NUM)-1:0] addr_o,
   output logic [7:0]                   m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   input  logic [7:0]                   s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast
);

   localparam int FRAME = 1 + DATA_BYTES;
   localparam int FW    = 8 * FRAME;
   localparam int CW    = $clog2(FRAME + 1);
   localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t                  state, state_nxt;
   logic [FW-1:0]           tx_sr;
   logic [CW-1:0]           tx_cnt;
   logic                    tx_valid;
   logic                    tx_done;
   logic [CW-1:0]           rx_cnt;
   logic [8*DATA_BYTES-1:0] rdata;
   logic                    err;
   logic [TW-1:0]           timer;
   logic [$clog2(SLAVE_NUM)-1:0] slave_sel;
   logic [8*DATA_BYTES-1:0] payload;
   logic                    cmd_hs, tx_hs, tx_last, rx_hs, rx_final, timeout;

   assign payload  = cmd_rw_i ? {DATA_BYTES{DUMMY_BYTE}} : cmd_wdata_i;
   assign cmd_hs   = cmd_valid_i & (state == IDLE);
   assign tx_last  = tx_valid & (tx_cnt == CW'(FRAME - 1));
   assign tx_hs    = tx_valid & m_axis_tready;
   // rx bytes outside XFER are accepted and dropped
   assign rx_hs    = (state == XFER) & s_axis_tvalid;
   assign rx_final = rx_hs & (rx_cnt == CW'(FRAME - 1));
   // rx handshake reloads the timer, so it wins over a coincident expiry
   assign timeout  = (state == XFER) & tx_done & ~rx_hs & (timer == '0);

   assign cmd_ready_o   = (state == IDLE);
   assign rsp_valid_o   = (state == RESP);
   assign rsp_rdata_o   = rdata;
   assign rsp_err_o     = err;
   assign addr_o        = slave_sel;
   assign m_axis_tdata  = tx_sr[FW-1 -: 8];
   assign m_axis_tvalid = tx_valid;
   assign m_axis_tlast  = tx_last;
   assign s_axis_tready = 1'b1;

   // state register
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_hs)               state_nxt = XFER;
         XFER:    if (rx_final || timeout)  state_nxt = RESP;
         RESP:    if (rsp_ready_i)          state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   // tx frame shifter: load on accept, shift out one byte per handshake
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         tx_sr     <= '0;
         tx_cnt    <= '0;
         tx_valid  <= 1'b0;
         tx_done   <= 1'b0;
         slave_sel <= '0;
      end else if (cmd_hs) begin
         tx_sr     <= {cmd_rw_i, cmd_addr_i, payload};
         tx_cnt    <= '0;
         tx_valid  <= 1'b1;
         tx_done   <= 1'b0;
         slave_sel <= cmd_slave_i;
      end else if (tx_hs) begin
         tx_sr  <= tx_sr << 8;
         tx_cnt <= tx_cnt + 1'b1;
         if (tx_last) begin
            tx_valid <= 1'b0;
            tx_done  <= 1'b1;
         end
      end
   end

   // rx collection: header echo dropped, payload placed by byte position
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rx_cnt <= '0;
         rdata  <= '0;
         err    <= 1'b0;
      end else if (cmd_hs) begin
         rx_cnt <= '0;
         rdata  <= '0;
         err    <= 1'b0;
      end else begin
         if (rx_hs) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (s_axis_tlast != (rx_cnt == CW'(FRAME - 1))) err <= 1'b1;
            for (int k = 1; k <= DATA_BYTES; k++) begin
               if (rx_cnt == CW'(k)) rdata[8*(DATA_BYTES-k) +: 8] <= s_axis_tdata;
            end
         end
         if (timeout) err <= 1'b1;
      end
   end

   // rx inactivity timer: down-counter, terminal count at zero
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         timer <= '0;
      end else if (cmd_hs || rx_hs) begin
         timer <= TW'(TIMEOUT - 1);
      end else if ((state == XFER) && tx_done && (timer != '0)) begin
         timer <= timer - 1'b1;
      end
   end

endmodule
